// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment/BCD types, segment patterns and scan FSM states
// Segment bit order is bit0=a .. bit6=g, active-high.
package seven_seg_pkg;
    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;
    typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_t;
    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to 7-segment decode, 10..15 blank
// Ports: bcd (digit in), seg (active-high segments out, bit0=a .. bit6=g).
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit 7-segment scanner with frame-aligned loads
// Ports: clk, reset (async, active-high), enable (0 = dark), digits_in/load (shadow capture),
//        load_ready (no unapplied load), seg_out, digit_sel (one-hot), frame_done (last dwell cycle).
// Optional: LEADING_ZERO_BLANK_EN blanks zero digits above the most-significant non-zero digit.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS     = 3,
    parameter int DWELL_CYCLES = 1000,
    parameter int DEAD_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic                  load,
    output logic                  load_ready,
    output seg_t                  seg_out,
    output logic [N_DIGITS-1:0]   digit_sel,
    output logic                  frame_done
);
    localparam int IW  = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int DWW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
    localparam int DEW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
    localparam int CW  = DWW > DEW ? DWW : DEW;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYCLES > 0 ? DEAD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    state_t                state, state_n;
    logic [IW-1:0]         idx, idx_n, idx_inc;
    logic [CW-1:0]         cnt, cnt_n;
    logic [4*N_DIGITS-1:0] buffer, shadow, buf_n;
    logic                  pending, pending_n, copy, wrap;
    logic [N_DIGITS-1:0]   blank;
    seg_t                  dec;

    assign idx_inc = idx == IDX_LAST ? '0 : idx + 1'b1;

    // One counter serves both dwell and dead phases; it restarts on every phase change.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + 1'b1;
        wrap    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else if (state == IDLE) begin
            state_n = DRIVE;
            idx_n   = '0;
            cnt_n   = '0;
        end else if (state == DRIVE && cnt == DWELL_LAST) begin
            cnt_n   = '0;
            state_n = DEAD_CYCLES > 0 ? DEAD : DRIVE;
            idx_n   = DEAD_CYCLES > 0 ? idx : idx_inc;
            wrap    = DEAD_CYCLES == 0 && idx == IDX_LAST;
        end else if (state == DEAD && cnt == DEAD_LAST) begin
            state_n = DRIVE;
            idx_n   = idx_inc;
            cnt_n   = '0;
            wrap    = idx == IDX_LAST;
        end
    end

    // Shadow reaches the buffer only at a frame wrap or while idle; a load on the
    // copy cycle is captured for the following frame and keeps pending set.
    assign copy      = state == IDLE || wrap;
    assign buf_n     = copy ? shadow : buffer;
    assign pending_n = copy ? load : (load | pending);

    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lz;
            lz = 1'b1;
            for (int i = N_DIGITS - 1; i > 0; i--) begin
                lz       = lz && buf_n[4*i +: 4] == 4'd0;
                blank[i] = lz;
            end
        end
`endif
    end

    bcd_to_seg u_dec (
        .bcd(buf_n[idx_n*4 +: 4]),
        .seg(dec)
    );

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            buffer     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            seg_out    <= SEG_BLANK;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            buffer     <= buf_n;
            if (load) shadow <= digits_in;
            pending    <= pending_n;
            load_ready <= ~pending_n;
            digit_sel  <= state_n == DRIVE ? N_DIGITS'(1) << idx_n : '0;
            seg_out    <= state_n == DRIVE && !blank[idx_n] ? dec : SEG_BLANK;
            frame_done <= state_n == DRIVE && idx_n == IDX_LAST && cnt_n == DWELL_LAST;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench for the 3-digit scan driver (dwell 4, dead 2)
module tb_seven_seg_scan_driver;
    localparam int DW = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, load = 1'b0;
    logic [11:0] digits_in = '0;
    logic        load_ready, frame_done;
    logic [6:0]  seg_out;
    logic [2:0]  digit_sel;
    int          tests = 0, errors = 0, cyc = 0, prev_fd = 0;
    bit          have_prev = 1'b0;
    logic [9:0]  exp_q[$];

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.N_DIGITS(3), .DWELL_CYCLES(DW), .DEAD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in), .load(load),
        .load_ready(load_ready), .seg_out(seg_out), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] b);
        case (b)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] shown(input logic [11:0] v, input int d);
        logic [3:0] nib;
        nib = v[4*d +: 4];
        if (LZB && d > 0 && (v >> (4*d)) == 12'h0) return 7'h00;
        return seg_of(nib);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [11:0] v);
        logic [2:0] s;
        for (int d = 0; d < 3; d++) begin
            s = 3'b001 << d;
            for (int k = 0; k < DW; k++) exp_q.push_back({s, shown(v, d)});
        end
    endtask

    task automatic wait_sel(input logic [2:0] s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (digit_sel !== s && n < 100);
        check("wait_sel", digit_sel, s);
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        check("wait_frame_done", frame_done, 1);
    endtask

    task automatic do_load(input logic [11:0] v);
        digits_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Monitor: every lit cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (digit_sel != 3'b000) begin
                tests++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_lit: got sel=%b seg=%h expected dark", digit_sel, seg_out);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({digit_sel, seg_out} !== e) begin
                        errors++;
                        $display("FAIL scan: got sel=%b seg=%h expected sel=%b seg=%h (t=%0t)",
                                 digit_sel, seg_out, e[9:7], e[6:0], $time);
                    end
                end
            end else check("dark_seg", seg_out, 0);
            if (frame_done) begin
                check("fd_on_last_digit", digit_sel, 3'b100);
                if (have_prev) check("fd_period", cyc - prev_fd, 18);
                prev_fd = cyc;
                have_prev = 1'b1;
            end
            if (!enable) have_prev = 1'b0;
            cyc++;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_seg", seg_out, 0);
        check("rst_sel", digit_sel, 0);
        check("rst_fd", frame_done, 0);
        check("rst_ready", load_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        do_load(12'h123);
        check("ready_low_idle", load_ready, 0);
        @(negedge clk);
        check("ready_back_idle", load_ready, 1);
        push_frame(12'h123);
        enable = 1'b1;
        wait_sel(3'b010);
        do_load(12'h456);
        check("ready_low_pending", load_ready, 0);
        push_frame(12'h456);
        wait_fd();
        check("ready_low_at_fd", load_ready, 0);
        wait_sel(3'b010);
        check("ready_after_wrap", load_ready, 1);
        digits_in = 12'h111;
        load = 1'b1;
        @(negedge clk);
        digits_in = 12'h999;
        @(negedge clk);
        load = 1'b0;
        push_frame(12'h999);
        wait_fd();
        wait_sel(3'b010);
        do_load(12'h1B5);
        exp_q.push_back({3'b001, seg_of(4'd5)});
        wait_fd();
        wait_sel(3'b001);
        enable = 1'b0;
        @(negedge clk);
        check("disable_sel", digit_sel, 0);
        check("disable_seg", seg_out, 0);
        repeat (3) @(negedge clk);
        push_frame(12'h1B5);
        enable = 1'b1;
        wait_sel(3'b010);
        do_load(12'h007);
        push_frame(12'h007);
        wait_fd();
        wait_fd();
        enable = 1'b0;
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        for (int k = 0; k < DW; k++) exp_q.push_back({3'b001, seg_of(4'd7)});
        exp_q.push_back({3'b010, shown(12'h007, 1)});
        enable = 1'b1;
        wait_sel(3'b010);
        #2 reset = 1'b1;
        #1;
        check("async_rst_seg", seg_out, 0);
        check("async_rst_sel", digit_sel, 0);
        check("async_rst_queue", exp_q.size(), 0);
        push_frame(12'h000);
        @(negedge clk);
        #2 reset = 1'b0;
        wait_sel(3'b001);
        wait_fd();
        enable = 1'b0;
        @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-bus 7-segment display, the parametrised successor of the single-digit decoder4x7.
- Holds a display buffer of N BCD digits.
- Scans one digit at a time, with a programmable dwell period and dead time between digits.
- Loads new values only at frame boundaries, so no digit ever shows a mixed old/new frame.
- Sits between the microwave timer/controller and the board display pins.

Parameters:
N_DIGITS, 3, number of digits scanned (1..8)
DWELL_CYCLES, 1000, clk cycles each digit is driven (>=1)
DEAD_CYCLES, 2, clk cycles all digits are off between digits (>=0; 0 = no dead time)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = scan display; 0 = all outputs dark
digits_in  input  4*N_DIGITS  BCD digits; digit 0 = bits [3:0] (rightmost)
load  input  1  one-cycle request to capture digits_in
load_ready  output  1  1 = no pending load (a new load is not overwriting an unapplied one)
seg_out  output  7  segments, active-high, bit0=a .. bit6=g
digit_sel  output  N_DIGITS  one-hot, active-high digit enable
frame_done  output  1  one-cycle pulse when the last digit's dwell ends

Behaviour:
- Reset (async, immediate): seg_out=0, digit_sel=0, frame_done=0, load_ready=1, display buffer=0, shadow=0, pending=0, digit index=0, FSM=IDLE.
- Decode:
  - 0..9 use standard patterns; 0 = 7'b0111111, 8 = 7'b1111111.
  - 10..15 decode to 7'b0000000 (blank).
- FSM states: IDLE, DRIVE, DEAD.
  - IDLE: outputs dark. enable=1 -> DRIVE with index 0 next cycle.
  - DRIVE: digit_sel=1<<index, seg_out=decode(buffer[index]) for DWELL_CYCLES cycles.
    - End of dwell, DEAD_CYCLES>0 -> DEAD.
    - End of dwell, DEAD_CYCLES=0 -> DRIVE on the next index.
  - DEAD: digit_sel=0, seg_out=0 for DEAD_CYCLES cycles, then DRIVE on the next index.
  - Index wraps N_DIGITS-1 -> 0.
  - enable=0 in any state -> IDLE next cycle, index reset to 0, dwell counter cleared. Buffer and shadow are kept.
- frame_done: asserted for the single cycle on which the dwell of index N_DIGITS-1 ends.
- Load path:
  - load=1 captures digits_in into the shadow register and sets pending; load_ready drops the following cycle.
  - At the frame boundary (index wraps to 0), or on any cycle while in IDLE, shadow is copied to the buffer and pending clears.
  - Load latency: at most one frame plus one cycle.
  - A load while pending overwrites the shadow; the last load wins and no error is raised.
  - A load on the same cycle as the boundary copy: the copy uses the old shadow, the new value is captured and pending stays set.
- Counter widths: $clog2 of DWELL_CYCLES, DEAD_CYCLES (min 1 bit) and N_DIGITS.
- All outputs are registered.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: zero digits above the most-significant non-zero digit decode as blank. Digit 0 is never blanked, so 0 shows as "  0". The blank decision uses the buffer contents, evaluated per frame.
- Undefined: all digits decode literally, so 0 shows as "000".

Decomposition:
- Package seven_seg_pkg:
  - SEG_BLANK constant.
  - Segment pattern constants for 0..9.
  - typedef seg_t (7-bit) and bcd_t (4-bit).
- One sub-module, bcd_to_seg: purely combinational decode of bcd_t to seg_t, matching decoder4x7 patterns with enable folded out.
- FSM, counters and load path stay in the top module.

Test Plan:
- Reset mid-DRIVE (index 1), reset=1 asynchronous -> seg_out=0 and digit_sel=0 in the same cycle; after release with enable=1, scan restarts at digit_sel=3'b001.
- N_DIGITS=3, DWELL=4, DEAD=2, load digits_in=12'h123, enable=1 -> sequence: 4 cycles sel=001/seg=decode(3), 2 dark cycles, then sel=010/seg=decode(2), then sel=100/seg=decode(1); frame_done pulses once per 18 cycles.
- Mid-frame load 12'h456 while showing 12'h123 -> remaining digits of the current frame still show 1,2,3; the next frame shows 4,5,6; load_ready is low until the boundary.
- Two loads in one frame (12'h111 then 12'h999) -> the next frame shows 9,9,9; 1,1,1 is never displayed.
- enable drops mid-scan -> dark the next cycle; re-enable -> restarts at index 0 with the buffer kept. A digit value of 4'hB -> seg_out=0 during its dwell.
- With LEADING_ZERO_BLANK_EN, buffer 12'h007 -> digits 2 and 1 show seg_out=0, digit 0 shows decode(7). Without the macro -> the display shows 0,0,7.
